// File: rtl/cpu_op_sequencer_pkg.sv
// Shared definitions for the CPU op sequencer: instruction fields, opcodes and FSM encoding.
// The ALU function selected by an ALU opcode is ~op[0] (ALU0 -> 0, ALU1 -> 1).
package cpu_op_sequencer_pkg;

    localparam int unsigned INSTR_W  = 9;
    localparam int unsigned OP_MSB   = 8;
    localparam int unsigned OP_LSB   = 7;
    localparam int unsigned REG_MSB  = 6;
    localparam int unsigned REG_LSB  = 5;
    localparam int unsigned ADDR_MSB = 4;
    localparam int unsigned ADDR_LSB = 0;

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_STORE = 2'b01;
    localparam logic [1:0] OP_ALU0  = 2'b11;
    localparam logic [1:0] OP_ALU1  = 2'b10;

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StMemRd,
        StMemWr,
        StAluRun,
        StWb
    } state_e;

endpackage

// File: rtl/cpu_op_sequencer_fifo.sv
// Instruction FIFO: DEPTH x WIDTH, registered pointers with an extra wrap bit.
// Push while full is refused even if a pop happens in the same cycle.
module op_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 9
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0]    wptr_q, rptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign empty   = (wptr_q == rptr_q);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem_q[rptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + PW'(1);
            if (do_pop)  rptr_q <= rptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/cpu_op_sequencer.sv
// Front-end sequencer: buffers instructions, issues them one at a time and times
// memory/ALU latencies before write-back and retirement.
module cpu_op_sequencer
    import cpu_op_sequencer_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned MEM_LAT = 2,
    parameter int unsigned ALU_LAT = 3,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [8:0]       instr,
    input  logic             instr_valid,
    output logic             instr_ready,
    output logic [1:0]       dp_op,
    output logic [1:0]       dp_reg,
    output logic [4:0]       dp_addr,
    output logic             mem_we,
    output logic             mem_oe,
    output logic             alu_go,
    output logic             rf_we,
    output logic             busy,
    output logic             retire,
    output logic [CNT_W-1:0] retired_cnt
);

    localparam int unsigned MAX_LAT = (MEM_LAT > ALU_LAT) ? MEM_LAT : ALU_LAT;
    localparam int unsigned LAT_W   = $clog2(MAX_LAT) + 1;
    localparam logic [LAT_W-1:0] MEM_LAST = LAT_W'(MEM_LAT - 1);
    localparam logic [LAT_W-1:0] ALU_LAST = LAT_W'(ALU_LAT - 1);

    state_e             state_q, state_d;
    logic [LAT_W-1:0]   lat_q, lat_d;
    logic [INSTR_W-1:0] cur_q, cur_d;
    logic [CNT_W-1:0]   cnt_q;
    logic               fifo_full, fifo_empty, fifo_pop;
    logic [INSTR_W-1:0] fifo_rdata;

    op_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (INSTR_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (instr_valid),
        .pop   (fifo_pop),
        .wdata (instr),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign instr_ready = !fifo_full;
    assign dp_op       = cur_q[OP_MSB:OP_LSB];
    assign dp_reg      = cur_q[REG_MSB:REG_LSB];
    assign dp_addr     = cur_q[ADDR_MSB:ADDR_LSB];
    assign busy        = (state_q != StIdle) || !fifo_empty;
    assign retired_cnt = cnt_q;

    always_comb begin
        state_d  = state_q;
        cur_d    = cur_q;
        fifo_pop = 1'b0;
        mem_we   = 1'b0;
        mem_oe   = 1'b0;
        alu_go   = 1'b0;
        rf_we    = 1'b0;
        retire   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    cur_d    = fifo_rdata;
                    state_d  = StIssue;
                end
            end
            StIssue: begin
                case (cur_q[OP_MSB:OP_LSB])
                    OP_LOAD:  state_d = StMemRd;
                    OP_STORE: state_d = StMemWr;
                    default: begin
                        alu_go  = 1'b1;
                        state_d = StAluRun;
                    end
                endcase
            end
            StMemRd: begin
                mem_oe = 1'b1;
                if (lat_q == MEM_LAST) state_d = StWb;
            end
            StMemWr: begin
                mem_we  = 1'b1;
                retire  = 1'b1;
                state_d = StIdle;
            end
            StAluRun: begin
                if (lat_q == ALU_LAST) state_d = StWb;
            end
            StWb: begin
                rf_we   = 1'b1;
                retire  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        // Latency counter restarts from zero whenever a new state is entered.
        lat_d = (state_d != state_q) ? '0 : lat_q + LAT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            lat_q   <= '0;
            cur_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
            cur_q   <= cur_d;
            if (retire) cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_cpu_op_sequencer.sv
// Directed bench for cpu_op_sequencer (DEPTH=4, MEM_LAT=2, ALU_LAT=3, CNT_W=4).
module tb_cpu_op_sequencer;

    localparam int unsigned CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [8:0]       instr = '0;
    logic             instr_valid = 1'b0;
    logic             instr_ready;
    logic [1:0]       dp_op, dp_reg;
    logic [4:0]       dp_addr;
    logic             mem_we, mem_oe, alu_go, rf_we, busy, retire;
    logic [CNT_W-1:0] retired_cnt;

    cpu_op_sequencer #(
        .DEPTH   (4),
        .MEM_LAT (2),
        .ALU_LAT (3),
        .CNT_W   (CNT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .dp_op       (dp_op),
        .dp_reg      (dp_reg),
        .dp_addr     (dp_addr),
        .mem_we      (mem_we),
        .mem_oe      (mem_oe),
        .alu_go      (alu_go),
        .rf_we       (rf_we),
        .busy        (busy),
        .retire      (retire),
        .retired_cnt (retired_cnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Monitor: samples settled outputs at each rising edge.
    int         cyc = 0, n_we = 0, n_oe = 0, n_go = 0, n_rf = 0, we_ret = 0, viol = 0;
    logic       last_busy = 1'b0;
    logic [8:0] ret_log[$];
    int         ret_cyc[$];
    int         go_cyc[$];
    logic [1:0] go_op[$];
    int         busy_rise[$];

    always @(posedge clk) begin
        cyc       <= cyc + 1;
        last_busy <= busy;
        if (mem_we) n_we <= n_we + 1;
        if (mem_oe) n_oe <= n_oe + 1;
        if (alu_go) n_go <= n_go + 1;
        if (rf_we)  n_rf <= n_rf + 1;
        if (mem_we && retire) we_ret <= we_ret + 1;
        if ((int'(mem_we) + int'(mem_oe) + int'(alu_go) + int'(rf_we)) > 1) viol <= viol + 1;
        if (busy && !last_busy) busy_rise.push_back(cyc);
        if (retire) begin
            ret_log.push_back({dp_op, dp_reg, dp_addr});
            ret_cyc.push_back(cyc);
        end
        if (alu_go) begin
            go_cyc.push_back(cyc);
            go_op.push_back(dp_op);
        end
    end

    int b_we, b_oe, b_go, b_rf, b_weret, b_ret, b_gq, b_rise;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic mark();
        b_we    = n_we;
        b_oe    = n_oe;
        b_go    = n_go;
        b_rf    = n_rf;
        b_weret = we_ret;
        b_ret   = ret_log.size();
        b_gq    = go_cyc.size();
        b_rise  = busy_rise.size();
    endtask

    // Entered and left on a falling edge; the transfer happens on the edge in between.
    task automatic push(input logic [8:0] i, output int waits);
        waits       = 0;
        instr       = i;
        instr_valid = 1'b1;
        while (!instr_ready && waits < 100) begin
            @(negedge clk);
            waits++;
        end
        check("push_accepted", 32'(instr_ready), 32'd1);
        @(negedge clk);
        instr_valid = 1'b0;
    endtask

    task automatic run_until(input string tag, input int n);
        int k = 0;
        while ((ret_log.size() - b_ret) < n && k < 300) begin
            @(negedge clk);
            k++;
        end
        check(tag, 32'(ret_log.size() - b_ret), 32'(n));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         w;
        logic [8:0] exp_q[$];

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(instr_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cnt", 32'(retired_cnt), 32'd0);
        check("rst_dp", 32'({dp_op, dp_reg, dp_addr}), 32'd0);
        check("rst_strobes", 32'({mem_we, mem_oe, alu_go, rf_we, retire}), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // STORE r2 @31
        mark();
        push(9'h0DF, w);
        run_until("store_done", 1);
        check("store_we_cycles", 32'(n_we - b_we), 32'd1);
        check("store_we_retire", 32'(we_ret - b_weret), 32'd1);
        check("store_fields", 32'(ret_log[b_ret]), 32'h0DF);
        check("store_occupancy", 32'(ret_cyc[b_ret] - busy_rise[b_rise] + 1), 32'd3);
        check("store_cnt", 32'(retired_cnt), 32'd1);

        // LOAD r1 @5
        mark();
        push(9'h025, w);
        run_until("load_done", 1);
        check("load_oe_cycles", 32'(n_oe - b_oe), 32'd2);
        check("load_rf_we", 32'(n_rf - b_rf), 32'd1);
        check("load_no_we", 32'(n_we - b_we), 32'd0);
        check("load_fields", 32'(ret_log[b_ret]), 32'h025);
        check("load_occupancy", 32'(ret_cyc[b_ret] - busy_rise[b_rise] + 1), 32'd5);
        check("load_cnt", 32'(retired_cnt), 32'd2);

        // ALU0 then ALU1 back-to-back
        mark();
        push(9'h180, w);
        push(9'h163, w);
        run_until("alu_done", 2);
        check("alu_go_count", 32'(n_go - b_go), 32'd2);
        check("alu_go_gap", 32'(go_cyc[b_gq + 1] - go_cyc[b_gq]), 32'd6);
        check("alu_op0", 32'(go_op[b_gq]), 32'd3);
        check("alu_op1", 32'(go_op[b_gq + 1]), 32'd2);
        check("alu_rf_we", 32'(n_rf - b_rf), 32'd2);
        check("alu_cnt", 32'(retired_cnt), 32'd4);

        // Back-pressure: LOAD stalls the sequencer while the FIFO fills
        mark();
        exp_q = {};
        push(9'h001, w);
        exp_q.push_back(9'h001);
        for (int i = 0; i < 5; i++) begin
            logic [8:0] v;
            v = {2'b01, 2'(i), 5'(10 + i)};
            exp_q.push_back(v);
            if (i == 4) check("stall_ready_low", 32'(instr_ready), 32'd0);
            push(v, w);
            if (i == 4) check("stall_wait", 32'(w), 32'd2);
        end
        run_until("stall_done", 6);
        for (int i = 0; i < 6; i++) check("stall_order", 32'(ret_log[b_ret + i]), 32'(exp_q[i]));
        check("stall_cnt", 32'(retired_cnt), 32'd10);

        // Reset during MEM_RD with a STORE queued behind
        mark();
        push(9'h025, w);
        push(9'h0DF, w);
        w = 0;
        while (!mem_oe && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("rst_mid_memrd", 32'(mem_oe), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_ready", 32'(instr_ready), 32'd1);
        check("rst_mid_cnt", 32'(retired_cnt), 32'd0);
        check("rst_mid_oe", 32'(mem_oe), 32'd0);
        check("rst_mid_dp", 32'({dp_op, dp_reg, dp_addr}), 32'd0);
        reset = 1'b0;
        repeat (8) @(negedge clk);
        check("rst_mid_no_rf_we", 32'(n_rf - b_rf), 32'd0);
        check("rst_mid_no_retire", 32'(ret_log.size() - b_ret), 32'd0);
        check("rst_mid_idle", 32'(busy), 32'd0);

        // Counter wrap after 16 retires
        mark();
        for (int i = 0; i < 15; i++) push({2'b01, 2'(i), 5'(i)}, w);
        run_until("wrap_15_done", 15);
        check("wrap_cnt_15", 32'(retired_cnt), 32'd15);
        push(9'h09F, w);
        run_until("wrap_16_done", 16);
        check("wrap_cnt_0", 32'(retired_cnt), 32'd0);

        check("strobe_exclusive", 32'(viol), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_op_sequencer.md
Name: cpu_op_sequencer

Overview:
Front-end controller for the 512-bit CPU datapath (4-entry register file, 2-function ALU, 32-entry memory unit). It accepts 9-bit instructions through a valid/ready handshake and buffers them in a small FIFO. Each instruction is issued to the datapath one at a time, and multi-cycle memory and ALU latencies are sequenced with a state machine. It drives the opcode, register-select, address and enable strobes the datapath consumes, and reports retirement.

Parameters:
DEPTH, 4, instruction FIFO entries (power of two, >=2)
MEM_LAT, 2, cycles memory read data takes to become valid after mem_oe asserts (>=1)
ALU_LAT, 3, cycles from alu_go to ALU result valid (>=1)
CNT_W, 16, width of retired-instruction counter

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high reset
instr  in  9  [8:7] opcode, [6:5] register, [4:0] memory address
instr_valid  in  1  instr present this cycle
instr_ready  out  1  FIFO not full; a transfer occurs when valid&ready
dp_op  out  2  opcode presented to register file/datapath muxes
dp_reg  out  2  register select
dp_addr  out  5  memory address
mem_we  out  1  memory write strobe (store)
mem_oe  out  1  memory read enable (load)
alu_go  out  1  one-cycle ALU start pulse
rf_we  out  1  register-file write-back strobe
busy  out  1  FSM not IDLE or FIFO non-empty
retire  out  1  one-cycle pulse when an instruction completes
retired_cnt  out  CNT_W  count of retired instructions, wraps

Behaviour:
- Opcodes: 2'b00 LOAD (mem->reg), 2'b01 STORE (reg->mem), 2'b11 ALU0, 2'b10 ALU1; ALU function = ~op[0].
- Reset: FIFO empty, FSM IDLE, all strobes 0, dp_op/dp_reg/dp_addr 0, retired_cnt 0, busy 0, instr_ready 1 on the first cycle after reset.
- FIFO: registered read/write pointers with extra wrap bit. Full when the pointers differ only in the MSB. A push in the same cycle as a pop when full is refused, because ready is based on the registered full flag. A push into an empty FIFO is not visible to the FSM until the next cycle.
- FSM states: IDLE, ISSUE, MEM_RD, MEM_WR, ALU_RUN, WB.
- IDLE: if FIFO non-empty, pop the head into a current-instruction register and go to ISSUE. dp_* is driven from that register and held constant until the instruction retires.
- ISSUE routing: LOAD -> MEM_RD; STORE -> MEM_WR; ALU0/ALU1 -> ALU_RUN with alu_go=1 for this cycle only.
- MEM_RD: mem_oe=1. Latency counter counts MEM_LAT cycles, then go to WB.
- MEM_WR: mem_we=1 for exactly one cycle. retire=1, then go to IDLE.
- ALU_RUN: latency counter counts ALU_LAT cycles, then go to WB.
- WB: rf_we=1 for one cycle. retire=1, then go to IDLE.
- The latency counter is cleared on every state entry, width clog2(max(MEM_LAT,ALU_LAT))+1.
- Minimum per-instruction occupancy: STORE 3 cycles (IDLE, ISSUE, MEM_WR); LOAD 3+MEM_LAT; ALU 3+ALU_LAT.
- At most one strobe of mem_we/mem_oe/alu_go/rf_we is high in any cycle; mem_oe and rf_we never overlap.
- retired_cnt increments on retire and wraps from all-ones to 0.
- Reset mid-operation: the in-flight instruction is dropped (no write-back), the FIFO is flushed, and all outputs return to reset values on the next edge.
- instr_valid with instr_ready=0: no state change; the producer must hold instr.

Decomposition:
- Shared package: opcode localparams (OP_LOAD, OP_STORE, OP_ALU0, OP_ALU1), FSM state encoding, instruction field bit positions.
- One sub-module: op_fifo (parameterised DEPTH x 9-bit synchronous FIFO with push/pop/full/empty), instantiated once.

Test Plan:
- Reset, then push STORE r2 @0x1F -> mem_we high exactly 1 cycle with dp_reg=2, dp_addr=31. retire in the same cycle; retired_cnt=1.
- Push LOAD r1 @5, MEM_LAT=2 -> mem_oe high 2 cycles, then rf_we 1 cycle with dp_reg=1; total 5 cycles from pop to retire.
- Push ALU0, then ALU1, back-to-back -> alu_go pulses 6 cycles apart (ALU_LAT=3), rf_we follows each. dp_op is 11, then 10.
- Stall the sequencer with a LOAD and push 5 instructions with DEPTH=4 -> instr_ready drops after the 4th accepted push. The 5th is held and accepted after the first pop, and all 5 retire in order.
- Assert reset during MEM_RD -> no rf_we, FIFO empty, busy=0, retired_cnt=0 next cycle.
- Preload retired_cnt near wrap (CNT_W=4) by issuing 16 STOREs -> counter reads 0 after the 16th retire.
